// File: rtl/stdp_pkg.sv
// stdp_pkg: shared defaults, timer saturation helper and STDP step-size helper.
package stdp_pkg;

   localparam int DEF_WINDOW   = 16;
   localparam int DEF_LR_SHIFT = 1;
   localparam int DEF_W_INIT   = 32;
   localparam int DEF_W_MAX    = 255;

   // All-ones timer value: "no spike seen for a long time", never inside the window
   function automatic int tmr_sat(input int tw);
      return (1 << tw) - 1;
   endfunction

   // Step magnitude for a spike-time difference already known to be inside the window
   function automatic int stdp_step(input int dt, input int window, input int lr_shift);
      int s;
      s = (window - dt) >> lr_shift;
      if (s < 1) s = 1;
      return s;
   endfunction

endpackage

// File: rtl/stdp_array_if.sv
// stdp_array_if: spike inputs, learning enable, weight readout and update flags.
interface stdp_array_if
   import stdp_pkg::*;
#(
   parameter int N_PRE = 5,
   parameter int WW    = 8
);
   localparam int SEL_W = (N_PRE > 1) ? $clog2(N_PRE) : 1;

   logic             ena;
   logic [N_PRE-1:0] pre_spike;
   logic             post_spike;
   logic [SEL_W-1:0] rd_sel;
   logic [WW-1:0]    rd_weight;
   logic [N_PRE-1:0] ltp_flag;
   logic [N_PRE-1:0] ltd_flag;

   modport master (
      output ena, pre_spike, post_spike, rd_sel,
      input  rd_weight, ltp_flag, ltd_flag
   );

   modport slave (
      input  ena, pre_spike, post_spike, rd_sel,
      output rd_weight, ltp_flag, ltd_flag
   );
endinterface

// File: rtl/stdp_synapse.sv
// stdp_synapse: one channel's pre timer, weight register and LTP/LTD decision.
module stdp_synapse
   import stdp_pkg::*;
#(
   parameter int TW       = 8,
   parameter int WW       = 8,
   parameter int WINDOW   = DEF_WINDOW,
   parameter int LR_SHIFT = DEF_LR_SHIFT,
   parameter int W_INIT   = DEF_W_INIT,
   parameter int W_MAX    = DEF_W_MAX
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ena,
   input  logic          pre_spike,
   input  logic          post_spike,
   input  logic [TW-1:0] post_t,
   output logic [WW-1:0] weight,
   output logic          ltp_flag,
   output logic          ltd_flag
);

   localparam logic [TW-1:0] T_SAT    = TW'(tmr_sat(TW));
   localparam logic [TW-1:0] WIN_T    = TW'(WINDOW);
   localparam logic [WW:0]   W_MAX_V  = (WW+1)'(W_MAX);
   localparam logic [WW-1:0] W_INIT_V = WW'(W_INIT);

   logic [TW-1:0] pre_t;
   logic          do_ltp;
   logic          do_ltd;
   logic [WW-1:0] ltp_step;
   logic [WW-1:0] ltd_step;

   // A step larger than W_MAX saturates anyway, so cap it to keep it in WW bits
   function automatic logic [WW-1:0] step_of(input logic [TW-1:0] dt);
      int s;
      s = stdp_step(int'(dt), WINDOW, LR_SHIFT);
      if (s > W_MAX) s = W_MAX;
      return WW'(s);
   endfunction

   function automatic logic [WW-1:0] sat_add(input logic [WW-1:0] a, input logic [WW-1:0] b);
      logic [WW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s > W_MAX_V) return W_MAX_V[WW-1:0];
      return s[WW-1:0];
   endfunction

   function automatic logic [WW-1:0] sat_sub(input logic [WW-1:0] a, input logic [WW-1:0] b);
      logic signed [WW+1:0] d;
      d = $signed({2'b00, a}) - $signed({2'b00, b});
      if (d < 0) return '0;
      return d[WW-1:0];
   endfunction

   // Simultaneous pre and post on this channel excludes both rules
   assign do_ltp   = ena & post_spike & ~pre_spike & (pre_t < WIN_T);
   assign do_ltd   = ena & pre_spike & ~post_spike & (post_t < WIN_T);
   assign ltp_step = step_of(pre_t);
   assign ltd_step = step_of(post_t);

   // Pre timer: restart on a spike, otherwise count up and park at saturation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              pre_t <= T_SAT;
      else if (pre_spike)      pre_t <= '0;
      else if (pre_t != T_SAT) pre_t <= pre_t + TW'(1);
   end

   // Weight update and one-cycle flags, decided from the timers held before the edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         weight   <= W_INIT_V;
         ltp_flag <= 1'b0;
         ltd_flag <= 1'b0;
      end else begin
         ltp_flag <= do_ltp;
         ltd_flag <= do_ltd;
         if (do_ltp)      weight <= sat_add(weight, ltp_step);
         else if (do_ltd) weight <= sat_sub(weight, ltd_step);
      end
   end

endmodule

// File: rtl/stdp_array.sv
// stdp_array: N_PRE STDP synapses sharing one post-synaptic timer, with registered readout.
module stdp_array
   import stdp_pkg::*;
#(
   parameter int N_PRE    = 5,
   parameter int TW       = 8,
   parameter int WW       = 8,
   parameter int WINDOW   = DEF_WINDOW,
   parameter int LR_SHIFT = DEF_LR_SHIFT,
   parameter int W_INIT   = DEF_W_INIT,
   parameter int W_MAX    = DEF_W_MAX
) (
   input logic         clk,
   input logic         rst_n,
   stdp_array_if.slave bus
);

   localparam int            SEL_W    = (N_PRE > 1) ? $clog2(N_PRE) : 1;
   localparam logic [TW-1:0] T_SAT    = TW'(tmr_sat(TW));
   localparam logic [WW-1:0] W_INIT_V = WW'(W_INIT);

   logic [TW-1:0]    post_t;
   logic [WW-1:0]    weights [N_PRE];
   logic [N_PRE-1:0] ltp_v;
   logic [N_PRE-1:0] ltd_v;
   logic [WW-1:0]    rd_next;

   // Post timer: restart on a post spike, otherwise count up and park at saturation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               post_t <= T_SAT;
      else if (bus.post_spike)  post_t <= '0;
      else if (post_t != T_SAT) post_t <= post_t + TW'(1);
   end

   for (genvar g = 0; g < N_PRE; g++) begin : g_syn
      stdp_synapse #(
         .TW       (TW),
         .WW       (WW),
         .WINDOW   (WINDOW),
         .LR_SHIFT (LR_SHIFT),
         .W_INIT   (W_INIT),
         .W_MAX    (W_MAX)
      ) u_syn (
         .clk        (clk),
         .rst_n      (rst_n),
         .ena        (bus.ena),
         .pre_spike  (bus.pre_spike[g]),
         .post_spike (bus.post_spike),
         .post_t     (post_t),
         .weight     (weights[g]),
         .ltp_flag   (ltp_v[g]),
         .ltd_flag   (ltd_v[g])
      );
   end

   assign bus.ltp_flag = ltp_v;
   assign bus.ltd_flag = ltd_v;

   // Readout mux; selects beyond the last channel read as zero
   always_comb begin
      rd_next = '0;
      for (int i = 0; i < N_PRE; i++) begin
         if (bus.rd_sel == SEL_W'(i)) rd_next = weights[i];
      end
   end

   // Registered readout shows the weight as it stood before this edge's update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bus.rd_weight <= W_INIT_V;
      else        bus.rd_weight <= rd_next;
   end

endmodule
